// File: rtl/control_sequencer.sv
// control_sequencer: next-state sequencer for the microprogrammed control unit
// Ports: clk, reset_n (async active-low), hold (freeze all registers this cycle),
//        sel/inv/cond/moc/cr_target/encoded_state (next-state selection inputs),
//        state_number (registered microstore address), mem_wait (stalled on moc),
//        ret_valid (return register valid), bus_error (moc timeout pulse).
// Optional: define SEQ_MOC_TIMEOUT_EN to abort a moc wait to FETCH_STATE after
//           MOC_TIMEOUT wait cycles with a one-cycle bus_error pulse.
module control_sequencer #(
    parameter int SW          = 10,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hold,
    input  logic [2:0]    sel,
    input  logic          inv,
    input  logic          cond,
    input  logic          moc,
    input  logic [SW-1:0] cr_target,
    input  logic [SW-1:0] encoded_state,
    output logic [SW-1:0] state_number,
    output logic          mem_wait,
    output logic          ret_valid,
    output logic          bus_error
);
    typedef enum logic {S_RUN, S_WAIT} fsm_t;
    fsm_t          fsm, fsm_nxt;
    logic [SW-1:0] ret_reg, ret_nxt, state_nxt, inc;
    logic          rv_nxt, timeout;
    assign inc      = state_number + 1'b1;
    // sel is only meaningful in RUN; in WAIT the frozen microinstruction still presents 100
    assign mem_wait = (fsm == S_WAIT) || (sel == 3'b100 && !moc);
`ifdef SEQ_MOC_TIMEOUT_EN
    localparam int CW = ($clog2(MOC_TIMEOUT + 1) < 4) ? 4 : $clog2(MOC_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // moc on the final wait cycle takes priority over the timeout
    assign timeout = (fsm == S_WAIT) && !moc && (cnt == CW'(MOC_TIMEOUT - 1));
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt       <= '0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= !hold && timeout;
            if (!hold)
                cnt <= (fsm == S_WAIT && !moc && !timeout) ? cnt + 1'b1 : '0;
        end
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif
    always_comb begin
        state_nxt = state_number;
        ret_nxt   = ret_reg;
        rv_nxt    = ret_valid;
        fsm_nxt   = fsm;
        if (fsm == S_WAIT) begin
            state_nxt = moc ? inc : timeout ? SW'(FETCH_STATE) : state_number;
            fsm_nxt   = (moc || timeout) ? S_RUN : S_WAIT;
        end else begin
            case (sel)
                3'b000: state_nxt = encoded_state;
                3'b001: state_nxt = SW'(FETCH_STATE);
                3'b010: state_nxt = (cond ^ inv) ? cr_target : inc;
                3'b011: state_nxt = inc;
                3'b100: begin
                    state_nxt = moc ? inc : state_number;
                    fsm_nxt   = moc ? S_RUN : S_WAIT;
                end
                3'b101: state_nxt = cr_target;
                3'b110: begin
                    state_nxt = cr_target;
                    ret_nxt   = inc;
                    rv_nxt    = 1'b1;
                end
                default: begin
                    state_nxt = ret_valid ? ret_reg : SW'(FETCH_STATE);
                    rv_nxt    = 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_number <= SW'(RESET_STATE);
            ret_reg      <= '0;
            ret_valid    <= 1'b0;
            fsm          <= S_RUN;
        end else if (!hold) begin
            state_number <= state_nxt;
            ret_reg      <= ret_nxt;
            ret_valid    <= rv_nxt;
            fsm          <= fsm_nxt;
        end
endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    localparam int SW = 10;
    localparam int NS = 1 << SW;
    localparam int FS = 1;
    localparam int TO = 15;
    logic          clk = 1'b0, reset_n = 1'b0, hold = 1'b0;
    logic          inv = 1'b0, cond = 1'b0, moc = 1'b0;
    logic [2:0]    sel = 3'b011;
    logic [SW-1:0] cr_target = '0, encoded_state = '0;
    logic [SW-1:0] state_number;
    logic          mem_wait, ret_valid, bus_error;
    int vectors = 0, errors = 0;
    int m_state, m_ret, m_cnt;
    bit m_rv, m_wait, m_berr;
    always #5 clk = ~clk;
    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .sel(sel), .inv(inv),
        .cond(cond), .moc(moc), .cr_target(cr_target), .encoded_state(encoded_state),
        .state_number(state_number), .mem_wait(mem_wait), .ret_valid(ret_valid),
        .bus_error(bus_error)
    );
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic void model_reset();
        m_state = 0; m_ret = 0; m_rv = 0; m_wait = 0; m_cnt = 0; m_berr = 0;
    endfunction
    // Spec-level reference: next address chosen from the current inputs
    function automatic void model_step();
        int nxt = (m_state + 1) % NS;
        m_berr = 0;
        if (hold) return;
        if (m_wait) begin
            if (moc) begin m_state = nxt; m_wait = 0; m_cnt = 0; end
`ifdef SEQ_MOC_TIMEOUT_EN
            else if (m_cnt + 1 == TO) begin m_state = FS; m_wait = 0; m_cnt = 0; m_berr = 1; end
            else m_cnt++;
`endif
            return;
        end
        case (int'(sel))
            0: m_state = int'(encoded_state);
            1: m_state = FS;
            2: m_state = (cond != inv) ? int'(cr_target) : nxt;
            3: m_state = nxt;
            4: if (moc) m_state = nxt; else m_wait = 1;
            5: m_state = int'(cr_target);
            6: begin m_ret = nxt; m_rv = 1; m_state = int'(cr_target); end
            default: begin m_state = m_rv ? m_ret : FS; m_rv = 0; end
        endcase
    endfunction
    task automatic cyc(input bit h, input int s, input bit iv, input bit c, input bit m,
                       input int tgt, input int enc);
        hold = h; sel = 3'(s); inv = iv; cond = c; moc = m;
        cr_target = SW'(tgt); encoded_state = SW'(enc);
        #1 chk("mem_wait", int'(mem_wait), int'(m_wait || (s == 4 && !m)));
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state_number", int'(state_number), m_state);
        chk("ret_valid", int'(ret_valid), int'(m_rv));
        chk("bus_error", int'(bus_error), int'(m_berr));
    endtask
    task automatic do_reset();
        #1 reset_n = 1'b0;
        #1 chk("async reset state", int'(state_number), 0);
        chk("reset ret_valid", int'(ret_valid), 0);
        chk("reset bus_error", int'(bus_error), 0);
        model_reset();
        #1 reset_n = 1'b1;
    endtask
    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        cyc(0, 3, 0, 0, 0, 0, 0);
        chk("inc after reset", int'(state_number), 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("fetch lit", int'(state_number), 1);
        cyc(0, 0, 0, 0, 0, 0, 66);
        chk("decode lit", int'(state_number), 66);
        cyc(0, 2, 1, 1, 0, 200, 0);
        chk("cjump not taken lit", int'(state_number), 67);
        cyc(0, 2, 0, 1, 0, 200, 0);
        chk("cjump taken lit", int'(state_number), 200);
        cyc(0, 0, 0, 0, 0, 0, 20);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4, 0, 0, 0, 0, 0);
            chk("moc wait held lit", int'(state_number), 20);
            chk("moc wait mem_wait lit", int'(mem_wait), 1);
        end
        cyc(0, 4, 0, 0, 1, 0, 0);
        chk("moc release lit", int'(state_number), 21);
        cyc(0, 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 30);
        cyc(0, 6, 0, 0, 0, 500, 0);
        chk("call lit", int'(state_number), 500);
        chk("call ret_valid lit", int'(ret_valid), 1);
        cyc(0, 7, 0, 0, 0, 0, 0);
        chk("ret lit", int'(state_number), 31);
        chk("ret ret_valid lit", int'(ret_valid), 0);
        cyc(0, 7, 0, 0, 0, 0, 0);
        chk("empty ret lit", int'(state_number), 1);
        cyc(1, 5, 0, 0, 0, 77, 0);
        cyc(1, 5, 0, 0, 0, 77, 0);
        chk("hold lit", int'(state_number), 1);
        cyc(0, 5, 0, 0, 0, 77, 0);
        chk("hold release lit", int'(state_number), 77);
        cyc(0, 0, 0, 0, 0, 0, 1022);
        cyc(0, 3, 0, 0, 0, 0, 0);
        chk("inc 1023 lit", int'(state_number), 1023);
        cyc(0, 3, 0, 0, 0, 0, 0);
        chk("wrap lit", int'(state_number), 0);
        cyc(0, 0, 0, 0, 0, 0, 40);
        cyc(0, 4, 0, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 1, 0, 0);
        chk("hold beats moc lit", int'(state_number), 40);
        do_reset();
        cyc(0, 3, 0, 0, 0, 0, 0);
        chk("reset aborts wait lit", int'(state_number), 1);
`ifdef SEQ_MOC_TIMEOUT_EN
        cyc(0, 0, 0, 0, 0, 0, 5);
        cyc(0, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 4, 0, 0, 0, 0, 0);
        chk("pre-timeout lit", int'(state_number), 5);
        cyc(0, 4, 0, 0, 0, 0, 0);
        chk("timeout state lit", int'(state_number), FS);
        chk("timeout bus_error lit", int'(bus_error), 1);
        cyc(0, 3, 0, 0, 0, 0, 0);
        chk("bus_error pulse lit", int'(bus_error), 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc($urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 3, int'($urandom_range(0, NS - 1)),
                int'($urandom_range(0, NS - 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
